// File: rtl/icache_mem_req_arbiter_pkg.sv
// icache_mem_req_arbiter_pkg: shared defaults and types for the icache fetch arbiter
package icache_mem_req_arbiter_pkg;
    localparam int ICACHE_ARB_NUM_REQ         = 2;
    localparam int ICACHE_ARB_MAX_OUTSTANDING = 4;
    localparam int ICACHE_ARB_ADDR_WIDTH      = 32;
    localparam int ICACHE_ARB_TAG_WIDTH       = 16;
    localparam int FETCH_DATA_WIDTH           = 256;
    typedef struct packed {
        logic [ICACHE_ARB_ADDR_WIDTH-1:0] addr;
        logic [ICACHE_ARB_TAG_WIDTH-1:0]  tag;
    } icache_arb_req_t;
    // wide enough to hold any returned source id and the requester count itself (up to 8)
    typedef logic [3:0] icache_arb_src_t;
endpackage

// File: rtl/icache_rr_arbiter.sv
// icache_rr_arbiter: combinational rotating-priority grant starting at ptr
module icache_rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    localparam logic [W:0] NN = (W+1)'(N);
    logic [W:0] c;
    logic       found;
    // walk the ring from ptr; the first asserted request wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = '0;
        for (int k = 0; k < N; k++) begin
            c = {1'b0, ptr} + (W+1)'(k);
            c = c >= NN ? c - NN : c;
            if (en && !found && req[c[W-1:0]]) begin
                found           = 1'b1;
                gnt[c[W-1:0]]   = 1'b1;
                idx             = c[W-1:0];
            end
        end
    end
endmodule

// File: rtl/icache_mem_req_arbiter.sv
// icache_mem_req_arbiter: round-robin share of the icache fetch channel with credit limit; ICACHE_ARB_DEMAND_PRIO_EN gives requester 0 priority
module icache_mem_req_arbiter
    import icache_mem_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = ICACHE_ARB_NUM_REQ,
    parameter int ADDR_WIDTH      = ICACHE_ARB_ADDR_WIDTH,
    parameter int TAG_WIDTH       = ICACHE_ARB_TAG_WIDTH,
    parameter int DATA_WIDTH      = FETCH_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = ICACHE_ARB_MAX_OUTSTANDING,
    parameter int SRC_W           = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_vld,
    output logic [NUM_REQ-1:0]              req_rdy,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
    output logic                            mem_req_vld,
    input  logic                            mem_req_rdy,
    output logic [ADDR_WIDTH-1:0]           mem_req_addr,
    output logic [SRC_W+TAG_WIDTH-1:0]      mem_req_tag,
    input  logic                            mem_ack_vld,
    output logic                            mem_ack_rdy,
    input  logic [DATA_WIDTH-1:0]           mem_ack_data,
    input  logic [SRC_W+TAG_WIDTH-1:0]      mem_ack_tag,
    output logic [NUM_REQ-1:0]              rsp_vld,
    input  logic [NUM_REQ-1:0]              rsp_rdy,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic [TAG_WIDTH-1:0]            rsp_tag,
    output logic [3:0]                      outstanding_cnt,
    output logic                            err_bad_src
);
    logic                 buf_vld;
    logic [SRC_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   rr_gnt, gnt;
    logic [SRC_W-1:0]     rr_idx, idx;
    logic                 slot, credit, fire, adv, bad, rsp_fire;
    icache_arb_src_t      src;

    assign slot   = !buf_vld || mem_req_rdy;
    assign credit = outstanding_cnt < 4'(MAX_OUTSTANDING);

`ifdef ICACHE_ARB_DEMAND_PRIO_EN
    logic dem;
    assign dem = slot && credit && req_vld[0];
    icache_rr_arbiter #(.N(NUM_REQ), .W(SRC_W)) u_arb (
        .req (req_vld & ~NUM_REQ'(1)),
        .ptr (rr_ptr),
        .en  (slot && (outstanding_cnt < 4'(MAX_OUTSTANDING - 1)) && !dem),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );
    assign gnt = dem ? NUM_REQ'(1) : rr_gnt;
    assign idx = dem ? '0 : rr_idx;
`else
    icache_rr_arbiter #(.N(NUM_REQ), .W(SRC_W)) u_arb (
        .req (req_vld),
        .ptr (rr_ptr),
        .en  (slot && credit),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );
    assign gnt = rr_gnt;
    assign idx = rr_idx;
`endif

    assign adv          = |rr_gnt;
    assign fire         = |gnt;
    assign req_rdy      = gnt;
    assign mem_req_vld  = buf_vld;

    // output stage: load on grant, empty on drain, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            if (fire) begin
                buf_vld      <= 1'b1;
                mem_req_addr <= req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                mem_req_tag  <= {idx, req_tag[idx*TAG_WIDTH +: TAG_WIDTH]};
            end else if (mem_req_rdy) begin
                buf_vld <= 1'b0;
            end
            if (adv)
                rr_ptr <= idx == SRC_W'(NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
    end

    assign src      = icache_arb_src_t'(mem_ack_tag[SRC_W+TAG_WIDTH-1 -: SRC_W]);
    assign bad      = src >= icache_arb_src_t'(NUM_REQ);
    assign rsp_fire = mem_ack_vld && mem_ack_rdy;
    assign rsp_data = mem_ack_data;
    assign rsp_tag  = mem_ack_tag[TAG_WIDTH-1:0];

    // steer the ack to its source; unknown sources are swallowed
    always_comb begin
        rsp_vld     = '0;
        mem_ack_rdy = bad;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src == icache_arb_src_t'(i)) begin
                rsp_vld[i]  = mem_ack_vld;
                mem_ack_rdy = rsp_rdy[i];
            end
        end
    end

    // credit counter and sticky bad-source flag
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_cnt <= '0;
            err_bad_src     <= 1'b0;
        end else begin
            if (fire && !rsp_fire)
                outstanding_cnt <= outstanding_cnt + 4'd1;
            else if (!fire && rsp_fire && outstanding_cnt != '0)
                outstanding_cnt <= outstanding_cnt - 4'd1;
            if (mem_ack_vld && bad)
                err_bad_src <= 1'b1;
        end
    end
endmodule

// File: tb/tb_icache_mem_req_arbiter.sv
// tb_icache_mem_req_arbiter: directed and random checks against a behavioural model
module tb_icache_mem_req_arbiter;
    localparam int NR = 3, MAXO = 4, AW = 32, TW = 16, DW = 256, SW = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic [NR-1:0] req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [NR*AW-1:0] req_addr;
    logic [NR*TW-1:0] req_tag;
    logic mem_req_vld, mem_req_rdy, mem_ack_vld, mem_ack_rdy, err_bad_src;
    logic [AW-1:0] mem_req_addr, a0;
    logic [SW+TW-1:0] mem_req_tag, mem_ack_tag;
    logic [DW-1:0] mem_ack_data, rsp_data;
    logic [TW-1:0] rsp_tag;
    logic [3:0] outstanding_cnt;

    int total = 0, nbad = 0;
    bit m_vld = 0, m_err = 0;
    int m_rr = 0, m_cnt = 0, dut_g = -1, n_gnt = 0;
    logic [AW-1:0] m_addr;
    logic [SW+TW-1:0] m_tag;

    icache_mem_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_tag(req_tag),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_ack_vld(mem_ack_vld), .mem_ack_rdy(mem_ack_rdy), .mem_ack_data(mem_ack_data), .mem_ack_tag(mem_ack_tag),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .outstanding_cnt(outstanding_cnt), .err_bad_src(err_bad_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", t, got, exp, $time);
        end
    endtask

    // one clock: compare against the model mid-cycle, advance the model, return at the next negedge
    task automatic step();
        int g, src;
        bit slot, badsrc, ear, fire;
        #1;
        slot = !m_vld || mem_req_rdy;
        g = -1;
        if (slot && m_cnt < MAXO)
            for (int k = 0; k < NR; k++)
                if (g < 0 && req_vld[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        src = int'(mem_ack_tag[SW+TW-1 -: SW]);
        badsrc = src >= NR;
        ear = badsrc ? 1'b1 : rsp_rdy[src];
        chk("req_rdy", req_rdy, g < 0 ? 0 : 1 << g);
        chk("mem_req_vld", mem_req_vld, m_vld);
        if (m_vld) begin
            chk("mem_req_addr", mem_req_addr, m_addr);
            chk("mem_req_tag", mem_req_tag, m_tag);
        end
        chk("outstanding_cnt", outstanding_cnt, m_cnt);
        chk("err_bad_src", err_bad_src, m_err);
        chk("rsp_vld", rsp_vld, (mem_ack_vld && !badsrc) ? 1 << src : 0);
        chk("mem_ack_rdy", mem_ack_rdy, ear);
        if (mem_ack_vld && !badsrc) begin
            chk("rsp_data", rsp_data, mem_ack_data);
            chk("rsp_tag", rsp_tag, mem_ack_tag[TW-1:0]);
        end
        dut_g = -1;
        for (int k = 0; k < NR; k++) if (req_rdy[k]) dut_g = k;
        if (dut_g >= 0) n_gnt++;
        fire = mem_ack_vld && ear;
        if (rst) begin
            m_vld = 0; m_rr = 0; m_cnt = 0; m_err = 0;
        end else begin
            if (g >= 0) begin
                m_vld = 1;
                m_addr = req_addr[g*AW +: AW];
                m_tag = {SW'(g), req_tag[g*TW +: TW]};
                m_rr = (g + 1) % NR;
            end else if (m_vld && mem_req_rdy) m_vld = 0;
            m_cnt = m_cnt + int'(g >= 0) - int'(fire);
            if (m_cnt < 0) m_cnt = 0;
            if (mem_ack_vld && badsrc) m_err = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        req_vld = '0; mem_ack_vld = 0; mem_req_rdy = 1; rsp_rdy = '1;
        mem_ack_tag = '0; mem_ack_data = '0;
    endtask

    task automatic do_rst();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        idle();
        req_addr = '0; req_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req_vld", mem_req_vld, 0);
        chk("rst_cnt", outstanding_cnt, 0);
        chk("rst_err", err_bad_src, 0);
        rst = 0;

        req_vld = 3'b010; req_addr[AW +: AW] = 32'h1000; req_tag[TW +: TW] = 16'h00AB;
        step();
        chk("single_gnt", dut_g, 1);
        req_vld = '0;
        chk("single_vld", mem_req_vld, 1);
        chk("single_addr", mem_req_addr, 32'h1000);
        chk("single_tag", mem_req_tag, 18'h100AB);
        chk("single_cnt", outstanding_cnt, 1);

        do_rst();
        req_vld = 3'b011; mem_ack_vld = 1; mem_ack_tag = {2'd0, 16'h1};
        for (int i = 0; i < 8; i++) begin
            step();
            chk("fair_gnt", dut_g, i % 2);
        end

        idle(); do_rst();
        req_vld = 3'b001; req_addr = {32'h3, 32'h2, 32'hCAFE0000};
        step();
        a0 = 32'hCAFE0000;
        req_addr = {32'h6, 32'h5, 32'h4};
        mem_req_rdy = 0;
        repeat (5) begin
            step();
            chk("bp_addr", mem_req_addr, a0);
            chk("bp_gnt", dut_g, -1);
        end
        mem_req_rdy = 1;
        step();
        chk("bp_issue", dut_g, 0);

        idle(); do_rst();
        req_vld = 3'b011; n_gnt = 0;
        repeat (6) step();
        chk("credit_gnts", n_gnt, 4);
        chk("credit_cnt", outstanding_cnt, 4);
        mem_ack_vld = 1; mem_ack_tag = {2'd0, 16'h2};
        step();
        chk("credit_same_cycle", n_gnt, 4);
        chk("credit_freed_cnt", outstanding_cnt, 3);
        step();
        chk("credit_regrant", n_gnt, 5);
        chk("credit_both_cnt", outstanding_cnt, 3);

        req_vld = '0; mem_ack_tag = {2'd1, 16'h0055}; rsp_rdy = 3'b101;
        repeat (3) begin
            #1;
            chk("steer_vld", rsp_vld, 3'b010);
            chk("steer_rdy", mem_ack_rdy, 0);
            step();
        end
        rsp_rdy = '1;
        step();
        chk("steer_dec", outstanding_cnt, 2);

        mem_ack_tag = {2'd3, 16'h0077};
        #1;
        chk("badsrc_rdy", mem_ack_rdy, 1);
        chk("badsrc_vld", rsp_vld, 0);
        step();
        mem_ack_vld = 0;
        chk("badsrc_err", err_bad_src, 1);
        chk("badsrc_cnt", outstanding_cnt, 1);

        req_vld = 3'b001; mem_req_rdy = 0;
        step(); step();
        rst = 1; step(); rst = 0;
        chk("rst_mid_vld", mem_req_vld, 0);
        chk("rst_mid_cnt", outstanding_cnt, 0);
        chk("rst_mid_err", err_bad_src, 0);

        repeat (3000) begin
            rst = $urandom_range(0, 199) == 0;
            mem_req_rdy = $urandom_range(0, 3) != 0;
            req_vld = NR'($urandom);
            req_addr = {$urandom, $urandom, $urandom};
            req_tag = 48'({$urandom, $urandom});
            mem_ack_vld = $urandom_range(0, 2) == 0;
            mem_ack_tag = {($urandom_range(0, 29) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), 16'($urandom)};
            mem_ack_data = {8{$urandom}};
            rsp_rdy = NR'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
